// File: rtl/fpsr_game_clock_professor.sv
// fpsr_game_clock_professor
//   Game-time base and professor-call generator for the game-state FSM.
//   Counts game minutes from Clk, raises professor calls at pseudo-random
//   minute intervals (MIN_GAP plus masked LFSR bits) and holds each call
//   until the FSM reports it has entered QUIZ.
//
// Ports
//   Clk            in   system clock
//   Reset          in   asynchronous, active-high reset
//   clear          in   synchronous game restart
//   run            in   advance game time
//   allow_call     in   FSM can accept a professor call now
//   in_quiz        in   FSM is in QUIZ; acknowledges an outstanding call
//   minutes        out  game minutes elapsed, saturates at 255
//   min_tick       out  one-cycle pulse on each minute boundary
//   professor_req  out  professor call, held until acknowledged
//   quiz_num       out  index of current/last call, saturates at 15
//   time_up        out  minutes >= MAX_MIN, registered one cycle behind minutes
module fpsr_game_clock_professor #(
  parameter int unsigned TICKS_PER_MIN = 100_000_000,
  parameter int unsigned MAX_MIN       = 120,
  parameter int unsigned MIN_GAP       = 5,
  parameter logic [7:0]  GAP_MASK      = 8'h07,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       run,
  input  logic       allow_call,
  input  logic       in_quiz,
  output logic [7:0] minutes,
  output logic       min_tick,
  output logic       professor_req,
  output logic [3:0] quiz_num,
  output logic       time_up
);

  // TICKS_PER_MIN is at least 2, so this width is at least 1.
  localparam int TICK_W = $clog2(TICKS_PER_MIN);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MIN - 1);
  localparam logic [8:0]        MIN_GAP_9 = 9'(MIN_GAP);

  localparam logic [1:0] ST_ARM  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_CALL = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [15:0]       lfsr_q, lfsr_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        minutes_q, minutes_d;
  logic              min_tick_q, min_tick_d;
  logic              time_up_q, time_up_d;
  logic [1:0]        pstate_q, pstate_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic              professor_req_q, professor_req_d;
  logic [3:0]        quiz_num_q, quiz_num_d;

  logic              tick_fire;
  logic [8:0]        gap_sum;
  logic [7:0]        gap_load;

  always_comb begin
    // Galois LFSR keeps running through clear and run=0 so the call
    // spacing differs from game to game.
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    tick_fire = run && (tick_cnt_q == TICK_LAST);
    gap_sum   = MIN_GAP_9 + {1'b0, lfsr_q[7:0] & GAP_MASK};
    gap_load  = gap_sum[8] ? 8'hFF : gap_sum[7:0];

    tick_cnt_d      = tick_cnt_q;
    minutes_d       = minutes_q;
    min_tick_d      = 1'b0;
    time_up_d       = (32'(minutes_q) >= MAX_MIN);
    pstate_d        = pstate_q;
    gap_cnt_d       = gap_cnt_q;
    professor_req_d = professor_req_q;
    quiz_num_d      = quiz_num_q;

    if (run) begin
      tick_cnt_d = tick_fire ? '0 : tick_cnt_q + 1'b1;
    end

    // The pulse still fires at 255 minutes; only the count saturates.
    if (tick_fire) begin
      min_tick_d = 1'b1;
      if (minutes_q != 8'hFF) begin
        minutes_d = minutes_q + 8'd1;
      end
    end

    case (pstate_q)
      ST_ARM: begin
        gap_cnt_d = gap_load;
        pstate_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // The minute boundary that zeroes gap_cnt is seen on the same edge
        // minutes increments, so the call issues one cycle later. With
        // allow_call low the call stays pending here.
        if (gap_cnt_q != 8'd0) begin
          if (tick_fire) begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end else if (allow_call) begin
          pstate_d        = ST_CALL;
          professor_req_d = 1'b1;
          if (quiz_num_q != 4'hF) begin
            quiz_num_d = quiz_num_q + 4'd1;
          end
        end
      end
      ST_CALL: begin
        if (in_quiz) begin
          professor_req_d = 1'b0;
          pstate_d        = ST_HOLD;
        end
      end
      default: begin
        if (!in_quiz) begin
          pstate_d = ST_ARM;
        end
      end
    endcase

    if (clear) begin
      tick_cnt_d      = '0;
      minutes_d       = 8'd0;
      min_tick_d      = 1'b0;
      time_up_d       = 1'b0;
      professor_req_d = 1'b0;
      quiz_num_d      = 4'd0;
      gap_cnt_d       = 8'd0;
      pstate_d        = ST_ARM;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q          <= LFSR_SEED;
      tick_cnt_q      <= '0;
      minutes_q       <= 8'd0;
      min_tick_q      <= 1'b0;
      time_up_q       <= 1'b0;
      pstate_q        <= ST_ARM;
      gap_cnt_q       <= 8'd0;
      professor_req_q <= 1'b0;
      quiz_num_q      <= 4'd0;
    end else begin
      lfsr_q          <= lfsr_d;
      tick_cnt_q      <= tick_cnt_d;
      minutes_q       <= minutes_d;
      min_tick_q      <= min_tick_d;
      time_up_q       <= time_up_d;
      pstate_q        <= pstate_d;
      gap_cnt_q       <= gap_cnt_d;
      professor_req_q <= professor_req_d;
      quiz_num_q      <= quiz_num_d;
    end
  end

  assign minutes       = minutes_q;
  assign min_tick      = min_tick_q;
  assign professor_req = professor_req_q;
  assign quiz_num      = quiz_num_q;
  assign time_up       = time_up_q;

endmodule

// File: tb/tb_fpsr_game_clock_professor.sv
// tb_fpsr_game_clock_professor
//   Self-checking bench for fpsr_game_clock_professor with a 4-cycle minute,
//   a fixed 2-minute call gap and time_up at 5 minutes. Each stimulus record
//   carries the outputs expected after its cycle count; the expectation is
//   queued when the stimulus is driven and compared when sampled.
module tb_fpsr_game_clock_professor;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       clear = 1'b0;
  logic       run = 1'b0;
  logic       allow_call = 1'b0;
  logic       in_quiz = 1'b0;
  logic [7:0] minutes;
  logic       min_tick;
  logic       professor_req;
  logic [3:0] quiz_num;
  logic       time_up;

  fpsr_game_clock_professor #(
    .TICKS_PER_MIN(4),
    .MAX_MIN(5),
    .MIN_GAP(2),
    .GAP_MASK(8'h00),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .clear(clear),
    .run(run),
    .allow_call(allow_call),
    .in_quiz(in_quiz),
    .minutes(minutes),
    .min_tick(min_tick),
    .professor_req(professor_req),
    .quiz_num(quiz_num),
    .time_up(time_up)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string tag;
    logic  clr;
    logic  rn;
    logic  allow;
    logic  iq;
    int    cycles;
    int    expMinutes;
    int    expTick;
    int    expReq;
    int    expQuiz;
    int    expTimeUp;
  } vec_t;

  vec_t expQ[$];
  vec_t tblA[$];
  int   nChecks = 0;
  int   nPass   = 0;

  function automatic vec_t mk(input string tag, input logic clr, input logic rn,
                              input logic allow, input logic iq, input int cycles,
                              input int m, input int t, input int r, input int q,
                              input int tu);
    vec_t v;
    v.tag = tag; v.clr = clr; v.rn = rn; v.allow = allow; v.iq = iq;
    v.cycles = cycles; v.expMinutes = m; v.expTick = t; v.expReq = r;
    v.expQuiz = q; v.expTimeUp = tu;
    return v;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expQ.size() == 0) begin
      checkVal("scoreboard_empty", 1, 0);
      return;
    end
    e = expQ.pop_front();
    checkVal({e.tag, ".minutes"},  int'(minutes),       e.expMinutes);
    checkVal({e.tag, ".min_tick"}, int'(min_tick),      e.expTick);
    checkVal({e.tag, ".req"},      int'(professor_req), e.expReq);
    checkVal({e.tag, ".quiz_num"}, int'(quiz_num),      e.expQuiz);
    checkVal({e.tag, ".time_up"},  int'(time_up),       e.expTimeUp);
  endtask

  // Drive a record, wait its cycles, sample #1 after the last edge.
  task automatic applyStimulus(input vec_t v);
    clear      = v.clr;
    run        = v.rn;
    allow_call = v.allow;
    in_quiz    = v.iq;
    expQ.push_back(v);
    repeat (v.cycles) @(posedge Clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    Reset = 1'b1; clear = 1'b0; run = 1'b0; allow_call = 1'b0; in_quiz = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    int  ticks, calls, minErr, quizErr, satTicks;
    logic prevReq;
    bit  reached;

    // Basic timebase plus call/acknowledge, edges counted from reset release.
    tblA.push_back(mk("a.e3",  0, 1, 1, 0, 3, 0, 0, 0, 0, 0));
    tblA.push_back(mk("a.e4",  0, 1, 1, 0, 1, 1, 1, 0, 0, 0));
    tblA.push_back(mk("a.e5",  0, 1, 1, 0, 1, 1, 0, 0, 0, 0));
    tblA.push_back(mk("a.e8",  0, 1, 1, 0, 3, 2, 1, 0, 0, 0));
    tblA.push_back(mk("a.e9",  0, 1, 1, 0, 1, 2, 0, 1, 1, 0));
    tblA.push_back(mk("a.e10", 0, 1, 1, 0, 1, 2, 0, 1, 1, 0));
    tblA.push_back(mk("a.e11", 0, 1, 1, 1, 1, 2, 0, 0, 1, 0));
    tblA.push_back(mk("a.e13", 0, 1, 1, 1, 2, 3, 0, 0, 1, 0));
    tblA.push_back(mk("a.e14", 0, 1, 1, 0, 1, 3, 0, 0, 1, 0));
    tblA.push_back(mk("a.e20", 0, 1, 1, 0, 6, 5, 1, 0, 1, 0));
    tblA.push_back(mk("a.e21", 0, 1, 1, 0, 1, 5, 0, 1, 2, 1));
    tblA.push_back(mk("a.e25", 0, 1, 0, 0, 4, 6, 0, 1, 2, 1));
    tblA.push_back(mk("a.e28", 0, 0, 0, 0, 3, 6, 0, 1, 2, 1));

    doReset();
    applyStimulus(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tblA[i]) applyStimulus(tblA[i]);

    // Deferred call: gap reaches zero with allow_call low for 10 minutes.
    doReset();
    applyStimulus(mk("b.e8", 0, 1, 0, 0, 8, 2, 1, 0, 0, 0));
    begin
      int reqSeen = 0;
      for (int c = 0; c < 39; c++) begin
        @(posedge Clk); #1;
        if (professor_req) reqSeen++;
      end
      checkVal("b.no_req_while_deferred", reqSeen, 0);
    end
    applyStimulus(mk("b.e48", 0, 1, 0, 0, 1, 12, 1, 0, 0, 1));
    applyStimulus(mk("b.e49", 0, 1, 1, 0, 1, 12, 0, 1, 1, 1));

    // Pause mid-minute; the partial minute and gap must resume exactly.
    doReset();
    applyStimulus(mk("c.e6",  0, 1, 0, 0, 6,  1, 0, 0, 0, 0));
    applyStimulus(mk("c.e26", 0, 0, 0, 1, 20, 1, 0, 0, 0, 0));
    applyStimulus(mk("c.e27", 0, 1, 1, 0, 1,  1, 0, 0, 0, 0));
    applyStimulus(mk("c.e28", 0, 1, 1, 0, 1,  2, 1, 0, 0, 0));
    applyStimulus(mk("c.e29", 0, 1, 1, 0, 1,  2, 0, 1, 1, 0));

    // Clear while a call is pending at minute 7, then a fresh game.
    doReset();
    applyStimulus(mk("d.e26", 0, 1, 0, 0, 26, 6, 0, 0, 0, 1));
    applyStimulus(mk("d.e27", 0, 1, 1, 0, 1,  6, 0, 1, 1, 1));
    applyStimulus(mk("d.e28", 0, 1, 1, 0, 1,  7, 1, 1, 1, 1));
    applyStimulus(mk("d.clr", 1, 1, 1, 0, 1,  0, 0, 0, 0, 0));
    applyStimulus(mk("d.e37", 0, 1, 1, 0, 8,  2, 1, 0, 0, 0));
    applyStimulus(mk("d.e38", 0, 1, 1, 0, 1,  2, 0, 1, 1, 0));

    // Long run to minute saturation, acknowledging every call.
    doReset();
    clear = 1'b0; run = 1'b1; allow_call = 1'b1; in_quiz = 1'b0;
    ticks = 0; calls = 0; minErr = 0; quizErr = 0; satTicks = 0;
    prevReq = 1'b0; reached = 1'b0;
    for (int c = 0; c < 1200 && !reached; c++) begin
      @(posedge Clk); #1;
      if (min_tick) ticks++;
      if (int'(minutes) != ((ticks > 255) ? 255 : ticks)) minErr++;
      if (professor_req && !prevReq) begin
        calls++;
        if (int'(quiz_num) != ((calls > 15) ? 15 : calls)) quizErr++;
      end
      prevReq = professor_req;
      in_quiz = professor_req;
      if (minutes == 8'hFF) reached = 1'b1;
    end
    checkVal("e.reached_255", int'(reached), 1);
    for (int c = 0; c < 24; c++) begin
      @(posedge Clk); #1;
      if (min_tick) satTicks++;
      if (minutes != 8'hFF) minErr++;
      if (professor_req && !prevReq) begin
        calls++;
        if (int'(quiz_num) != ((calls > 15) ? 15 : calls)) quizErr++;
      end
      prevReq = professor_req;
      in_quiz = professor_req;
    end
    checkVal("e.minutes_held", int'(minutes), 255);
    checkVal("e.ticks_at_255", satTicks, 6);
    checkVal("e.minute_trace_errors", minErr, 0);
    checkVal("e.at_least_16_calls", int'(calls >= 16), 1);
    checkVal("e.quiz_trace_errors", quizErr, 0);
    checkVal("e.quiz_saturated", int'(quiz_num), 15);
    checkVal("e.time_up", int'(time_up), 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
